swc_page_alloc_arbiter: RTL
===========================

// Module: swc_page_alloc_arbiter
// PURPOSE
//  Shares the single-ported multicast page allocator among the g_num_ports
//  input blocks of the switch core. Round-robin arbitration; one alloc or free
//  operation in flight at a time; per-port ack on completion; watchdog on the
//  allocator handshake. Sits between the swc_core input blocks and the allocator.
// PARAMETERS
//  g_num_ports        7    number of requesting input blocks (>=2)
//  g_page_addr_width  10   page address width
//  g_timeout          255  WAIT-state cycles before the operation is aborted (>=2)
// PORTS
//  clk_i            in   1        system clock
//  rst_i            in   1        synchronous reset, active high
//  req_i            in   N        per-port request; held until that port's ack
//  free_i           in   N        per-port op select: 1 = free page, 0 = allocate page
//  free_pgaddr_i    in   N*W      per-port page to free; port p in [(p+1)*W-1:p*W]
//  ack_o            out  N        one-hot one-cycle completion pulse
//  pgaddr_o         out  W        allocated page; valid in the ack_o cycle
//  nomem_o          out  1        alloc failed (no memory or timeout); valid in the ack_o cycle
//  timeout_o        out  1        one-cycle pulse on watchdog expiry
//  alloc_o          out  1        one-cycle strobe to allocator: allocate
//  free_o           out  1        one-cycle strobe to allocator: free
//  free_pgaddr_o    out  W        page to free; valid with free_o
//  done_i           in   1        allocator completion pulse
//  pgaddr_alloc_i   in   W        allocator result; valid with done_i
//  nomem_i          in   1        allocator out of pages; valid with done_i
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; RR pointer = N-1, so port 0 is first.
//  FSM states: IDLE, ISSUE, WAIT, ACK; all outputs registered.
//  - IDLE: if |req_i, grant the first requesting port searching from ptr+1 mod N
//    upward with wrap. Latch grant index, free_i[g] and free_pgaddr_i[g].
//    Next state ISSUE. No request: stay in IDLE.
//  - ISSUE (1 cycle): alloc_o = ~free_g or free_o = free_g. free_pgaddr_o = the
//    latched address when freeing, else 0. Clear the watchdog. Next state WAIT.
//  - WAIT: sample done_i only here. done_i=1: latch pgaddr_alloc_i and nomem_i.
//    For a free op, latch pgaddr = 0 and nomem = 0. Next state ACK.
//    No done_i: increment the watchdog. Watchdog == g_timeout-1: timeout_o=1,
//    pgaddr = 0, nomem = 1, next state ACK.
//  - ACK (1 cycle): ack_o[g]=1; pgaddr_o/nomem_o driven with the latched values,
//    else 0. ptr <= g. Next state IDLE.
//  - Latency: req in IDLE at cycle t -> strobe at t+1. done_i at cycle d -> ack at d+1.
//    Minimum cycle per operation is 4 cycles, with done_i in the first WAIT cycle.
//  - Requests are sampled only in IDLE. req_i changes during ISSUE/WAIT/ACK are ignored.
//  - A requester dropping req mid-operation does not cancel it; the ack still fires.
//  - A requester must drop req the cycle after its ack. The RR pointer has already
//    moved past it, so it cannot starve others.
//  - done_i outside WAIT is ignored. This includes a late done_i after a timeout,
//    which produces no ack.
//  - Strobes are mutually exclusive; exactly one per operation.
//  - rst_i mid-operation: return to IDLE the next cycle. No ack is issued.
//    The allocator is reset by the same rst_i.
//  - Counters: watchdog is ceil(log2(g_timeout+1)) bits and saturates.
//    The pointer wraps N-1 -> 0.
// TESTING
//  1. Single req: port 3 alloc, done_i 2 cycles after alloc_o with pgaddr 0x05A
//     -> ack_o=0x08 and pgaddr_o=0x05A one cycle after done_i, nomem_o=0.
//  2. All 7 ports req simultaneously, done_i immediate
//     -> acks in order 0,1,...,6, one every 4 cycles, no port served twice.
//  3. Port 2 free of page 0x1FF -> free_o=1 with free_pgaddr_o=0x1FF,
//     alloc_o=0, ack_o=0x04.
//  4. Alloc with done_i never asserted, g_timeout=8 -> timeout_o pulse 8 cycles
//     into WAIT, then ack with nomem_o=1, pgaddr_o=0. A later stray done_i is ignored.
//  5. done_i with nomem_i=1 -> ack with nomem_o=1. Next request is served normally.
//  6. rst_i during WAIT -> all outputs 0 next cycle, no ack.
//     Port 0 is served first after release.

Source files
------------

// File: rtl/swc_page_alloc_arbiter.sv
// Round-robin arbiter that shares the single-ported page allocator among the
// switch input blocks. Only one alloc/free operation is in flight at a time, and a watchdog guards the allocator handshake.
module swc_page_alloc_arbiter #(
    parameter int g_num_ports       = 7,
    parameter int g_page_addr_width = 10,
    parameter int g_timeout         = 255
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [g_num_ports-1:0]                     req_i,
    input  logic [g_num_ports-1:0]                     free_i,
    input  logic [g_num_ports*g_page_addr_width-1:0]   free_pgaddr_i,
    output logic [g_num_ports-1:0]                     ack_o,
    output logic [g_page_addr_width-1:0]               pgaddr_o,
    output logic                                       nomem_o,
    output logic                                       timeout_o,
    output logic                                       alloc_o,
    output logic                                       free_o,
    output logic [g_page_addr_width-1:0]               free_pgaddr_o,
    input  logic                                       done_i,
    input  logic [g_page_addr_width-1:0]               pgaddr_alloc_i,
    input  logic                                       nomem_i
);

    localparam int N   = g_num_ports;
    localparam int W   = g_page_addr_width;
    localparam int PW  = $clog2(N);
    localparam int WDW = $clog2(g_timeout + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  grant_q, grant_d;
    logic           freeOp_q, freeOp_d;
    logic [WDW-1:0] wdog_q, wdog_d;

    logic [N-1:0]   ack_q, ack_d;
    logic [W-1:0]   pgaddr_q, pgaddr_d;
    logic           nomem_q, nomem_d;
    logic           timeout_q, timeout_d;
    logic           alloc_q, alloc_d;
    logic           free_q, free_d;
    logic [W-1:0]   freePgaddr_q, freePgaddr_d;

    logic           found;
    logic [PW-1:0]  sel;
    logic           wdogExpired;

    // Round-robin search starting one past the last served port
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + 1 + i) % N;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    assign wdogExpired = (wdog_q == WDW'(g_timeout - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            ptr_q        <= PW'(N - 1);
            grant_q      <= '0;
            freeOp_q     <= 1'b0;
            wdog_q       <= '0;
            ack_q        <= '0;
            pgaddr_q     <= '0;
            nomem_q      <= 1'b0;
            timeout_q    <= 1'b0;
            alloc_q      <= 1'b0;
            free_q       <= 1'b0;
            freePgaddr_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            freeOp_q     <= freeOp_d;
            wdog_q       <= wdog_d;
            ack_q        <= ack_d;
            pgaddr_q     <= pgaddr_d;
            nomem_q      <= nomem_d;
            timeout_q    <= timeout_d;
            alloc_q      <= alloc_d;
            free_q       <= free_d;
            freePgaddr_q <= freePgaddr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        freeOp_d = freeOp_q;
        wdog_d   = wdog_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = sel;
                    freeOp_d = free_i[sel];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_i || wdogExpired) begin
                    state_d = ACK;
                end else if (wdog_q != {WDW{1'b1}}) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ACK: begin
                ptr_d   = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers load the value each output must show in the following state
    always_comb begin
        ack_d        = '0;
        pgaddr_d     = '0;
        nomem_d      = 1'b0;
        timeout_d    = 1'b0;
        alloc_d      = 1'b0;
        free_d       = 1'b0;
        freePgaddr_d = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    alloc_d = ~free_i[sel];
                    free_d  = free_i[sel];
                    if (free_i[sel]) begin
                        freePgaddr_d = free_pgaddr_i[int'(sel)*W +: W];
                    end
                end
            end
            WAIT: begin
                if (done_i) begin
                    ack_d[grant_q] = 1'b1;
                    if (!freeOp_q) begin
                        pgaddr_d = pgaddr_alloc_i;
                        nomem_d  = nomem_i;
                    end
                end else if (wdogExpired) begin
                    ack_d[grant_q] = 1'b1;
                    timeout_d      = 1'b1;
                    nomem_d        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ack_o         = ack_q;
    assign pgaddr_o      = pgaddr_q;
    assign nomem_o       = nomem_q;
    assign timeout_o     = timeout_q;
    assign alloc_o       = alloc_q;
    assign free_o        = free_q;
    assign free_pgaddr_o = freePgaddr_q;

endmodule
